// File: rtl/bus_port_pkg.sv
// bus_port_pkg: shared constants, types and helpers for the bus device port.
//   ADDR_W       destination address width (packet MSBs)
//   BCAST_ADDR   default broadcast destination
//   sat_cnt_t    16-bit saturating event counter
//   dest_of()    extracts the destination field of a packet of width w
//   sat_inc()    increments a counter, holding at all-ones
package bus_port_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_PKT_W = 256;
    localparam int unsigned IDX_W     = 8;

    localparam logic [ADDR_W-1:0] BCAST_ADDR = 8'hFF;

    typedef logic [CNT_W-1:0] sat_cnt_t;

    // Packet is zero-extended to MAX_PKT_W by the caller; w is its real width.
    function automatic logic [ADDR_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                  input int unsigned w);
        return pkt[IDX_W'(w - ADDR_W) +: ADDR_W];
    endfunction

    function automatic sat_cnt_t sat_inc(input sat_cnt_t cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bus_port_fifo.sv
// bus_port_fifo: first-word fall-through circular FIFO.
//   clk, reset (sync, active-low)
//   wr/din   : write request and data; accepted when not full, or when a
//              same-cycle read frees the head slot
//   rd       : read request; ignored while empty
//   dout     : head entry, forced to 0 while empty
//   full/empty decoded from the registered occupancy count
module bus_port_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned depth = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] din,
    input  logic         rd,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned OCC_W = $clog2(depth + 1);

    logic [W-1:0]     mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == OCC_W'(depth));
    assign empty = (count == '0);
    assign rd_ok = rd & ~empty;
    // When full, a same-cycle read makes room (full implies non-empty).
    assign wr_ok = wr & (~full | rd);
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
            if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale entries are hidden by the empty forcing.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bus_device_port.sv
// bus_device_port: device-side endpoint of the bus arbiter FIFO protocol.
//   TX: tx_wr/tx_data -> FIFO -> pndng/D_pop/pop (arbiter side);
//       tx_full status, tx_ovf one-cycle pulse on a dropped write.
//   RX: push/D_push (arbiter side) -> address filter -> FIFO ->
//       rx_valid/rx_data/rx_rd; rx_drop_cnt counts accepted packets lost to a
//       full RX FIFO, rx_miss_cnt counts filtered-out packets.
//   clk, reset (sync, active-low).
// Build option: BUS_PORT_ADDR_CHECK_EN enables the destination filter;
// without it every push is accepted and rx_miss_cnt stays 0.
module bus_device_port
    import bus_port_pkg::*;
#(
    parameter int unsigned      tama_de_paquete = 16,
    parameter int unsigned      tam_fifo        = 12,
    parameter logic [ADDR_W-1:0] ID             = 8'h00,
    parameter logic [ADDR_W-1:0] broadcast      = BCAST_ADDR
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       pndng,
    output logic [tama_de_paquete-1:0] D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [tama_de_paquete-1:0] D_push,
    input  logic                       tx_wr,
    input  logic [tama_de_paquete-1:0] tx_data,
    output logic                       tx_full,
    output logic                       tx_ovf,
    input  logic                       rx_rd,
    output logic [tama_de_paquete-1:0] rx_data,
    output logic                       rx_valid,
    output logic [CNT_W-1:0]           rx_drop_cnt,
    output logic [CNT_W-1:0]           rx_miss_cnt
);

`ifdef BUS_PORT_ADDR_CHECK_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic              tx_empty;
    logic              rx_empty;
    logic              rx_full;
    logic [ADDR_W-1:0] dest_c;
    logic              addr_hit_c;
    logic              rx_accept_c;
    logic              rx_miss_c;
    logic              rx_drop_c;
    logic              tx_drop_c;

    // Destination filter; when disabled every push counts as a hit.
    assign dest_c      = dest_of(MAX_PKT_W'(D_push), tama_de_paquete);
    assign addr_hit_c  = (dest_c == ID) || (dest_c == broadcast);
    assign rx_accept_c = push & (addr_hit_c | ~FILTER_EN);
    assign rx_miss_c   = push & ~addr_hit_c & FILTER_EN;
    assign rx_drop_c   = rx_accept_c & rx_full & ~rx_rd;
    assign tx_drop_c   = tx_wr & tx_full & ~pop;

    bus_port_fifo #(.W(tama_de_paquete), .depth(tam_fifo)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .din   (tx_data),
        .rd    (pop),
        .dout  (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    bus_port_fifo #(.W(tama_de_paquete), .depth(tam_fifo)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (rx_accept_c),
        .din   (D_push),
        .rd    (rx_rd),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign pndng    = ~tx_empty;
    assign rx_valid = ~rx_empty;

    // Overflow pulse and saturating event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_ovf      <= 1'b0;
            rx_drop_cnt <= '0;
            rx_miss_cnt <= '0;
        end else begin
            tx_ovf <= tx_drop_c;
            if (rx_drop_c) rx_drop_cnt <= sat_inc(rx_drop_cnt);
            if (rx_miss_c) rx_miss_cnt <= sat_inc(rx_miss_cnt);
        end
    end

endmodule

// File: tb/tb_bus_device_port.sv
module tb_bus_device_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic        tx_ovf;
    logic        rx_rd;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] rx_drop_cnt;
    logic [15:0] rx_miss_cnt;

    int passed = 0;
    int total  = 0;

    bus_device_port #(
        .tama_de_paquete(16),
        .tam_fifo       (12),
        .ID             (8'h02),
        .broadcast      (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_ovf     (tx_ovf),
        .rx_rd      (rx_rd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_drop_cnt(rx_drop_cnt),
        .rx_miss_cnt(rx_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply the currently driven inputs for one edge, then idle them.
    task automatic step();
        @(posedge clk);
        #1;
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, " pndng"},    32'(pndng), 32'd0);
        chk({tag, " D_pop"},    32'(D_pop), 32'd0);
        chk({tag, " tx_full"},  32'(tx_full), 32'd0);
        chk({tag, " tx_ovf"},   32'(tx_ovf), 32'd0);
        chk({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, " rx_data"},  32'(rx_data), 32'd0);
        chk({tag, " drop"},     32'(rx_drop_cnt), 32'd0);
        chk({tag, " miss"},     32'(rx_miss_cnt), 32'd0);
    endtask

    logic [15:0] q[$];
    logic [15:0] exp_v;

    initial begin
        reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        tx_data = '0; D_push = '0;
        step(); step();
        reset = 1'b1;
        chk_zero_state("reset");

        // Basic TX ordering
        tx_wr = 1'b1; tx_data = 16'h0211; step();
        chk("tx first pndng", 32'(pndng), 32'd1);
        chk("tx first D_pop", 32'(D_pop), 32'h0211);
        tx_wr = 1'b1; tx_data = 16'h0322; step();
        tx_wr = 1'b1; tx_data = 16'h0433; step();
        chk("tx head held", 32'(D_pop), 32'h0211);
        pop = 1'b1; step();
        chk("pop1", 32'(D_pop), 32'h0322);
        pop = 1'b1; step();
        chk("pop2", 32'(D_pop), 32'h0433);
        pop = 1'b1; step();
        chk("pop3 pndng", 32'(pndng), 32'd0);
        chk("pop3 D_pop", 32'(D_pop), 32'd0);

        // TX full, overflow, and write-with-pop while full
        for (int i = 0; i < 12; i++) begin
            tx_wr = 1'b1; tx_data = 16'h1000 + 16'(i); step();
        end
        chk("tx full", 32'(tx_full), 32'd1);
        chk("tx no ovf yet", 32'(tx_ovf), 32'd0);
        tx_wr = 1'b1; tx_data = 16'h1EEE; step();
        chk("tx ovf pulse", 32'(tx_ovf), 32'd1);
        chk("tx still full", 32'(tx_full), 32'd1);
        step();
        chk("tx ovf one cycle", 32'(tx_ovf), 32'd0);
        tx_wr = 1'b1; tx_data = 16'h1FFF; pop = 1'b1; step();
        chk("wr+pop full ovf", 32'(tx_ovf), 32'd0);
        chk("wr+pop full stays", 32'(tx_full), 32'd1);
        for (int i = 1; i < 12; i++) begin
            exp_v = 16'h1000 + 16'(i);
            chk("drain head", 32'(D_pop), 32'(exp_v));
            pop = 1'b1; step();
        end
        chk("drain last", 32'(D_pop), 32'h1FFF);
        pop = 1'b1; step();
        chk("drained pndng", 32'(pndng), 32'd0);
        pop = 1'b1; step();
        chk("pop empty ignored", 32'(pndng), 32'd0);
        tx_wr = 1'b1; tx_data = 16'h0777; pop = 1'b1; step();
        chk("wr+pop empty pndng", 32'(pndng), 32'd1);
        chk("wr+pop empty D_pop", 32'(D_pop), 32'h0777);
        pop = 1'b1; step();
        chk("wr+pop empty drained", 32'(pndng), 32'd0);

        // RX address filter
        push = 1'b1; D_push = 16'h02AA; step();
        chk("rx latency valid", 32'(rx_valid), 32'd1);
        chk("rx latency data", 32'(rx_data), 32'h02AA);
        push = 1'b1; D_push = 16'hFFBB; step();
        push = 1'b1; D_push = 16'h05CC; step();
`ifdef BUS_PORT_ADDR_CHECK_EN
        chk("rx miss cnt", 32'(rx_miss_cnt), 32'd1);
`else
        chk("rx miss cnt", 32'(rx_miss_cnt), 32'd0);
`endif
        rx_rd = 1'b1; step();
        chk("rx bcast", 32'(rx_data), 32'hFFBB);
        rx_rd = 1'b1; step();
`ifdef BUS_PORT_ADDR_CHECK_EN
        chk("rx filtered empty", 32'(rx_valid), 32'd0);
        chk("rx filtered data0", 32'(rx_data), 32'd0);
`else
        chk("rx unfiltered", 32'(rx_data), 32'h05CC);
        rx_rd = 1'b1; step();
        chk("rx unfiltered empty", 32'(rx_valid), 32'd0);
`endif
        rx_rd = 1'b1; step();
        chk("rx rd empty ignored", 32'(rx_valid), 32'd0);

        // RX full: drops, then push with same-cycle read
        for (int i = 0; i < 12; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i); step();
        end
        chk("rx full head", 32'(rx_data), 32'h0200);
        push = 1'b1; D_push = 16'h02E0; step();
        push = 1'b1; D_push = 16'h02E1; step();
        chk("rx drop cnt", 32'(rx_drop_cnt), 32'd2);
        push = 1'b1; D_push = 16'h02F0; rx_rd = 1'b1; step();
        chk("rx push+rd no drop", 32'(rx_drop_cnt), 32'd2);
        for (int i = 1; i < 12; i++) begin
            exp_v = 16'h0200 + 16'(i);
            chk("rx drain", 32'(rx_data), 32'(exp_v));
            rx_rd = 1'b1; step();
        end
        chk("rx drain last", 32'(rx_data), 32'h02F0);
        rx_rd = 1'b1; step();
        chk("rx drained", 32'(rx_valid), 32'd0);

        // TX pointer wrap with occupancy held at 1..2
        q.delete();
        for (int i = 0; i < 30; i++) begin
            tx_wr = 1'b1; tx_data = 16'h3000 + 16'(i);
            pop = (q.size() >= 2);
            if (pop) void'(q.pop_front());
            q.push_back(tx_data);
            step();
            chk("wrap head", 32'(D_pop), 32'(q[0]));
        end
        while (q.size() > 0) begin
            chk("wrap drain", 32'(D_pop), 32'(q[0]));
            void'(q.pop_front());
            pop = 1'b1; step();
        end
        chk("wrap empty", 32'(pndng), 32'd0);

        // Reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1'b1; tx_data = 16'h4000 + 16'(i); step();
        end
        push = 1'b1; D_push = 16'h0201; step();
        chk("pre-reset pndng", 32'(pndng), 32'd1);
        chk("pre-reset rx_valid", 32'(rx_valid), 32'd1);
        reset = 1'b0; push = 1'b1; D_push = 16'h0299; tx_wr = 1'b1; tx_data = 16'h4999;
        step();
        reset = 1'b1;
        chk_zero_state("midreset");
        step();
        chk("post-reset rx_valid", 32'(rx_valid), 32'd0);
        chk("post-reset pndng", 32'(pndng), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
